// File: rtl/audio_sample_fifo_if.sv
// rtl/audio_sample_fifo_if.sv - audio frame write/read strobes, output frame and status flags
interface audio_sample_fifo_if #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16
);
    localparam int AW = $clog2(DEPTH);

    logic                      in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      audio_sample;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic [AW:0]               level;
    logic                      overflow;
    logic                      underflow;
    logic                      primed;

    modport master (
        output in_valid, in_data, audio_sample,
        input  out_data, level, overflow, underflow, primed
    );

    modport slave (
        input  in_valid, in_data, audio_sample,
        output out_data, level, overflow, underflow, primed
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - multi-channel audio frame FIFO with overflow/underflow flags
// Optional FILL/RUN prefill state machine built when AUDIO_FIFO_PREFILL_EN is defined.
module audio_sample_fifo #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16
) (
    input logic               clk,
    input logic               reset,
    audio_sample_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = CHANNELS * WIDTH;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [FW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_q;
    logic [FW-1:0] out_q;
    logic          overflow_q;
    logic          underflow_q;
    logic          primed_q;
    logic          run;

    logic empty, full, rd_req, pop, uf_hit, drop;

    assign empty  = (level_q == '0);
    assign full   = (level_q == FULL_LVL);
    assign rd_req = bus.audio_sample && run;
    assign pop    = rd_req && !empty;
    assign uf_hit = rd_req && empty;
    // A pop frees the slot the full-buffer write needs, so only pop-less full writes drop.
    assign drop   = bus.in_valid && full && !pop;

`ifdef AUDIO_FIFO_PREFILL_EN
    localparam logic [AW:0] HALF_LVL = (AW+1)'(DEPTH / 2);

    typedef enum logic {FILL, RUN} state_t;
    state_t state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FILL;
            primed_q <= 1'b0;
        end else begin
            case (state)
                FILL: if (level_q >= HALF_LVL) begin
                    state    <= RUN;
                    primed_q <= 1'b1;
                end
                RUN: if (uf_hit) begin
                    state    <= FILL;
                    primed_q <= 1'b0;
                end
                default: begin
                    state    <= FILL;
                    primed_q <= 1'b0;
                end
            endcase
        end
    end

    assign run = (state == RUN);
`else
    assign run      = 1'b1;
    assign primed_q = 1'b1;
`endif

    // Storage is not reset; level and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (bus.in_valid)
            mem[wr_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= drop;
            underflow_q <= uf_hit;
            if (bus.in_valid)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop || drop)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (pop)
                out_q <= mem[rd_ptr];
            if (bus.in_valid && !drop && !pop)
                level_q <= level_q + LVL_ONE;
            else if (pop && !bus.in_valid)
                level_q <= level_q - LVL_ONE;
        end
    end

    assign bus.out_data  = out_q;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
    assign bus.primed    = primed_q;
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb/tb_audio_sample_fifo.sv - randomized and directed check of audio_sample_fifo against a queue model
module tb_audio_sample_fifo;
    localparam int CHANNELS = 2;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 16;
    localparam int FW       = CHANNELS * WIDTH;

    logic clk = 1'b0;
    logic reset = 1'b1;

    audio_sample_fifo_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    audio_sample_fifo #(.CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [FW-1:0] mq[$];
    logic [FW-1:0] m_out;
    logic          m_run;
    logic          m_of;
    logic          m_uf;

`ifdef AUDIO_FIFO_PREFILL_EN
    localparam logic PRIMED_AT_RESET = 1'b0;
`else
    localparam logic PRIMED_AT_RESET = 1'b1;
`endif

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_out = '0;
        m_run = PRIMED_AT_RESET;
        m_of  = 1'b0;
        m_uf  = 1'b0;
    endtask

    // Frame-queue view of the buffer: reads are taken before the same cycle's write.
    task automatic model_cycle(input logic w, input logic r, input logic [FW-1:0] d);
        int  start_lvl;
        logic popped;
        start_lvl = mq.size();
        popped = 1'b0;
        m_of = 1'b0;
        m_uf = 1'b0;
        if (r && m_run) begin
            if (mq.size() > 0) begin
                m_out = mq.pop_front();
                popped = 1'b1;
            end else begin
                m_uf = 1'b1;
            end
        end
        if (w) begin
            if (mq.size() == DEPTH && !popped) begin
                void'(mq.pop_front());
                m_of = 1'b1;
            end
            mq.push_back(d);
        end
`ifdef AUDIO_FIFO_PREFILL_EN
        if (!m_run && start_lvl >= DEPTH / 2)
            m_run = 1'b1;
        else if (m_run && m_uf)
            m_run = 1'b0;
`else
        if (start_lvl < 0)
            m_run = 1'b0;
`endif
    endtask

    task automatic compare_all(input string where);
        check_val({where, ".out_data"},  64'(bus.out_data),  64'(m_out));
        check_val({where, ".level"},     64'(bus.level),     64'(mq.size()));
        check_val({where, ".overflow"},  64'(bus.overflow),  64'(m_of));
        check_val({where, ".underflow"}, 64'(bus.underflow), 64'(m_uf));
        check_val({where, ".primed"},    64'(bus.primed),    64'(m_run));
    endtask

    task automatic step(input string where, input logic w, input logic r, input logic [FW-1:0] d);
        bus.in_valid     = w;
        bus.audio_sample = r;
        bus.in_data      = d;
        @(posedge clk);
        model_cycle(w, r, d);
        #1;
        bus.in_valid     = 1'b0;
        bus.audio_sample = 1'b0;
        compare_all(where);
    endtask

    task automatic do_reset();
        bus.in_valid     = 1'b0;
        bus.audio_sample = 1'b0;
        bus.in_data      = '0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pw;
        int pr;
        do_reset();
        compare_all("reset");

        // Three frames in, three out, in order.
        step("w1", 1'b1, 1'b0, 32'h0001_0002);
        step("w2", 1'b1, 1'b0, 32'h0003_0004);
        step("w3", 1'b1, 1'b0, 32'h0005_0006);
        step("r1", 1'b0, 1'b1, '0);
`ifndef AUDIO_FIFO_PREFILL_EN
        check_val("r1.const", 64'(bus.out_data), 64'h0001_0002);
`endif
        step("r2", 1'b0, 1'b1, '0);
        step("r3", 1'b0, 1'b1, '0);
`ifndef AUDIO_FIFO_PREFILL_EN
        check_val("r3.const", 64'(bus.out_data), 64'h0005_0006);
        check_val("r3.level", 64'(bus.level), 64'd0);
`endif

        // Overflow: 17 writes, oldest frame lost.
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            step("ovf_w", 1'b1, 1'b0, FW'(i));
            if (i == 16) check_val("ovf.no_pulse16", 64'(bus.overflow), 64'd0);
        end
        check_val("ovf.pulse", 64'(bus.overflow), 64'd1);
        check_val("ovf.level", 64'(bus.level), 64'd16);
        step("ovf_idle", 1'b0, 1'b0, '0);
        check_val("ovf.one_cycle", 64'(bus.overflow), 64'd0);

        // Simultaneous read+write at full.
        step("full_rw", 1'b1, 1'b1, 32'hAAAA_0018);
        check_val("full_rw.of", 64'(bus.overflow), 64'd0);
        check_val("full_rw.level", 64'(bus.level), 64'd16);
        check_val("full_rw.out", 64'(bus.out_data), 64'd2);
        for (int i = 3; i <= 17; i++) begin
            step("ovf_r", 1'b0, 1'b1, '0);
            check_val("ovf_r.const", 64'(bus.out_data), 64'(i));
        end
        step("drain_last", 1'b0, 1'b1, '0);
        check_val("drain_last.out", 64'(bus.out_data), 64'hAAAA_0018);

        // Simultaneous read+write when empty in RUN: underflow and write kept.
        step("empty_rw", 1'b1, 1'b1, 32'h1234_5678);
        check_val("empty_rw.uf", 64'(bus.underflow), 64'd1);
        check_val("empty_rw.level", 64'(bus.level), 64'd1);

`ifndef AUDIO_FIFO_PREFILL_EN
        // Underflow hold on an empty buffer.
        step("hold_pop", 1'b0, 1'b1, '0);
        check_val("hold_pop.out", 64'(bus.out_data), 64'h1234_5678);
        step("hold_uf", 1'b0, 1'b1, '0);
        check_val("hold.out", 64'(bus.out_data), 64'h1234_5678);
        check_val("hold.uf", 64'(bus.underflow), 64'd1);
        step("hold_idle", 1'b0, 1'b0, '0);
        check_val("hold.uf_clear", 64'(bus.underflow), 64'd0);
`else
        // Prefill: output withheld until half full.
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            step("pf_w", 1'b1, 1'b1, FW'(i));
            check_val("pf.out0", 64'(bus.out_data), 64'd0);
            check_val("pf.primed0", 64'(bus.primed), 64'd0);
        end
        step("pf_w8", 1'b1, 1'b0, FW'(8));
        step("pf_wait", 1'b0, 1'b0, '0);
        check_val("pf.primed1", 64'(bus.primed), 64'd1);
        step("pf_r1", 1'b0, 1'b1, '0);
        check_val("pf.first", 64'(bus.out_data), 64'd1);
        for (int i = 0; i < 7; i++) step("pf_drain", 1'b0, 1'b1, '0);
        step("pf_uf", 1'b0, 1'b1, '0);
        check_val("pf.primed_drop", 64'(bus.primed), 64'd0);
`endif

        // Asynchronous reset between edges at level 5.
        do_reset();
        for (int i = 0; i < 5; i++) step("mid_w", 1'b1, 1'b0, $urandom);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step("post_rst_rd", 1'b0, 1'b1, '0);
        check_val("post_rst.uf", 64'(bus.underflow), 64'(PRIMED_AT_RESET));

        // Randomized traffic with shifting bias to reach full and empty.
        pw = 50;
        pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                pw = 10 + 30 * int'($urandom_range(2));
                pr = 10 + 30 * int'($urandom_range(2));
            end
            step("rand", ($urandom_range(99) < pw), ($urandom_range(99) < pr), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
